vga_dither_out: RTL

VGA_DITHER_OUT -- requirements
Module: vga_dither_out

---
 rtl/vga_pkg.sv | 62 ++++++
 rtl/vga_dither_ch.sv | 40 ++++
 rtl/vga_dither_out.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA dither output block:
//   - CH_W / Q_W        : input colour channel width and quantised width
//   - PMOD_* positions  : bit positions of each signal in the TinyVGA PMOD byte
//                         {hsync,B[0],G[0],R[0],vsync,B[1],G[1],R[1]}
//   - stage1_t          : contents of the first pipeline register
//   - bayer()           : 4x4 ordered-dither threshold table
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int CH_W = 4;
   localparam int Q_W  = 2;

   localparam int PMOD_HSYNC = 7;
   localparam int PMOD_B0    = 6;
   localparam int PMOD_G0    = 5;
   localparam int PMOD_R0    = 4;
   localparam int PMOD_VSYNC = 3;
   localparam int PMOD_B1    = 2;
   localparam int PMOD_G1    = 1;
   localparam int PMOD_R1    = 0;

   // Pixel as captured by stage 1; only the top two threshold bits matter
   // because the quantiser compares them against the two dropped colour bits.
   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
      logic            hsync;
      logic            vsync;
      logic            de;
      logic            dither_en;
      logic [1:0]      t_hi;
   } stage1_t;

   // 4x4 Bayer matrix, indexed {row, col}.
   function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] t;
      case ({row, col})
         4'd0:    t = 4'd0;
         4'd1:    t = 4'd8;
         4'd2:    t = 4'd2;
         4'd3:    t = 4'd10;
         4'd4:    t = 4'd12;
         4'd5:    t = 4'd4;
         4'd6:    t = 4'd14;
         4'd7:    t = 4'd6;
         4'd8:    t = 4'd3;
         4'd9:    t = 4'd11;
         4'd10:   t = 4'd1;
         4'd11:   t = 4'd9;
         4'd12:   t = 4'd15;
         4'd13:   t = 4'd7;
         4'd14:   t = 4'd13;
         4'd15:   t = 4'd5;
         default: t = 4'd0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/vga_dither_ch.sv
// -----------------------------------------------------------------------------
// vga_dither_ch
// Combinational quantiser for one colour channel (4 bits -> 2 bits).
//   c_i         : channel value from stage 1
//   t_hi_i      : top two bits of the Bayer threshold for this pixel
//   dither_en_i : 1 = ordered dither, 0 = plain truncation
//   de_i        : display enable; colour is blanked to 0 when low
//   q_o         : quantised 2-bit channel
// -----------------------------------------------------------------------------
module vga_dither_ch
   import vga_pkg::*;
(
   input  logic [CH_W-1:0] c_i,
   input  logic [1:0]      t_hi_i,
   input  logic            dither_en_i,
   input  logic            de_i,
   output logic [Q_W-1:0]  q_o
);

   logic [2:0] sum_s;

   // Round up when the discarded bits exceed the threshold, saturate at 3.
   always_comb begin
      sum_s = {1'b0, c_i[3:2]};
      q_o   = 2'b00;
      if (dither_en_i && (c_i[1:0] > t_hi_i)) begin
         sum_s = {1'b0, c_i[3:2]} + 3'd1;
      end else begin
         sum_s = {1'b0, c_i[3:2]};
      end
      if (!de_i) begin
         q_o = 2'b00;
      end else if (sum_s > 3'd3) begin
         q_o = 2'b11;
      end else begin
         q_o = sum_s[1:0];
      end
   end

endmodule

// File: rtl/vga_dither_out.sv
// -----------------------------------------------------------------------------
// vga_dither_out
// Final VGA output stage: 4-bit-per-channel colour is reduced to 2 bits per
// channel with optional (temporally rotating) ordered dither and packed into
// the TinyVGA PMOD byte. Two-stage pipeline; syncs travel with their pixel.
//   clk, reset              : pixel clock, asynchronous active-high reset
//   in_r/in_g/in_b [3:0]    : pixel colour
//   in_hsync, in_vsync      : active-high syncs
//   in_de                   : display enable
//   in_x, in_y [1:0]        : low bits of pixel position
//   dither_en               : 1 = dither, 0 = truncate
//   uo_out [7:0]            : PMOD byte {hs,B0,G0,R0,vs,B1,G1,R1}
//   frame_cnt [7:0]         : frames seen since reset (wraps)
//   frame_tick              : high in the cycle a vsync rising edge is seen
// -----------------------------------------------------------------------------
module vga_dither_out
   import vga_pkg::*;
#(
   parameter int SYNC_INV = 0,
   parameter int TEMPORAL = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [CH_W-1:0] in_r,
   input  logic [CH_W-1:0] in_g,
   input  logic [CH_W-1:0] in_b,
   input  logic            in_hsync,
   input  logic            in_vsync,
   input  logic            in_de,
   input  logic [1:0]      in_x,
   input  logic [1:0]      in_y,
   input  logic            dither_en,
   output logic [7:0]      uo_out,
   output logic [7:0]      frame_cnt,
   output logic            frame_tick
);

   localparam logic       SINV      = (SYNC_INV != 0);
   localparam logic [7:0] SYNC_MASK = 8'((1 << PMOD_HSYNC) | (1 << PMOD_VSYNC));
   // Reset shows idle (deasserted) syncs at the configured polarity.
   localparam logic [7:0] UO_RST    = SINV ? SYNC_MASK : 8'h00;

   logic       vs_prev_q;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       frame_tick_s;
   logic [1:0] f_s, row_s, col_s;
   logic [3:0] t_s;
   stage1_t    s1_q, s1_d;
   logic [Q_W-1:0] q_r_s, q_g_s, q_b_s;
   logic [7:0] uo_q, uo_d;

   // Frame edge detect and counter next state. The tick is combinational so
   // it coincides with the cycle whose pixel still uses the old count.
   always_comb begin
      frame_tick_s = in_vsync & ~vs_prev_q;
      frame_cnt_d  = frame_cnt_q;
      if (frame_tick_s) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
   end

   // Stage 1 next state: capture pixel and look up its dither threshold.
   always_comb begin
      f_s   = (TEMPORAL != 0) ? frame_cnt_q[1:0] : 2'b00;
      row_s = in_y + f_s;
      col_s = in_x + f_s;
      t_s   = bayer(row_s, col_s);
      s1_d           = '0;
      s1_d.r         = in_r;
      s1_d.g         = in_g;
      s1_d.b         = in_b;
      s1_d.hsync     = in_hsync;
      s1_d.vsync     = in_vsync;
      s1_d.de        = in_de;
      s1_d.dither_en = dither_en;
      s1_d.t_hi      = t_s[3:2];
   end

   vga_dither_ch u_ch_r (
      .c_i         (s1_q.r),
      .t_hi_i      (s1_q.t_hi),
      .dither_en_i (s1_q.dither_en),
      .de_i        (s1_q.de),
      .q_o         (q_r_s)
   );

   vga_dither_ch u_ch_g (
      .c_i         (s1_q.g),
      .t_hi_i      (s1_q.t_hi),
      .dither_en_i (s1_q.dither_en),
      .de_i        (s1_q.de),
      .q_o         (q_g_s)
   );

   vga_dither_ch u_ch_b (
      .c_i         (s1_q.b),
      .t_hi_i      (s1_q.t_hi),
      .dither_en_i (s1_q.dither_en),
      .de_i        (s1_q.de),
      .q_o         (q_b_s)
   );

   // Stage 2 next state: pack quantised colour and polarity-adjusted syncs.
   always_comb begin
      uo_d             = 8'h00;
      uo_d[PMOD_HSYNC] = s1_q.hsync ^ SINV;
      uo_d[PMOD_B0]    = q_b_s[0];
      uo_d[PMOD_G0]    = q_g_s[0];
      uo_d[PMOD_R0]    = q_r_s[0];
      uo_d[PMOD_VSYNC] = s1_q.vsync ^ SINV;
      uo_d[PMOD_B1]    = q_b_s[1];
      uo_d[PMOD_G1]    = q_g_s[1];
      uo_d[PMOD_R1]    = q_r_s[1];
   end

   // Frame counter and vsync history; history resets high so a vsync that is
   // already asserted when reset releases does not count as a new frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_prev_q   <= 1'b1;
         frame_cnt_q <= 8'h00;
      end else begin
         vs_prev_q   <= in_vsync;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Pipeline registers for stage 1 and stage 2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= '0;
         uo_q <= UO_RST;
      end else begin
         s1_q <= s1_d;
         uo_q <= uo_d;
      end
   end

   assign uo_out     = uo_q;
   assign frame_cnt  = frame_cnt_q;
   assign frame_tick = frame_tick_s;

endmodule
